// File: rtl/uart_pkg.sv
// Shared definitions for the multi-format UART receiver.
// Register map, control/status bit positions, FSM states and FIFO entry.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE2 = 2'd3
  } parity_e;

  localparam int CTL_BITS_LSB = 0;
  localparam int CTL_PAR_LSB  = 2;
  localparam int CTL_STOP2    = 4;
  localparam int CTL_IRQ_EN   = 5;

  localparam logic [5:0] CTRL_RESET = 6'h03;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_BRK     = 3;
  localparam int ST_BUSY    = 4;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_multi_if.sv
// Peripheral-bus request/ready handshake for the UART receiver.
// The CPU side is the master, the receiver is the slave.
interface uart_rx_multi_if;
  logic        i_request;
  logic        i_rw;
  logic [1:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with fill count and a registered head word.
// A pop on full frees the slot for a same-cycle push.
module uart_rx_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_nxt;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_FULL);
  assign o_count  = r_count;
  assign o_head   = r_head;
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign w_rd_nxt = w_pop ? r_rd + 1'b1 : r_rd;

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      r_rd    <= w_rd_nxt;
      r_count <= r_count + {{AW{1'b0}}, w_push}
                         - {{AW{1'b0}}, w_pop};
      // a word landing on the new head slot bypasses the array
      if (w_push && r_wr == w_rd_nxt) r_head <= i_wdata;
      else                            r_head <= r_mem[w_rd_nxt];
    end
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Runtime-configurable UART receiver with 3-sample majority vote,
// error-tagged receive FIFO and sticky overrun/break flags.
import uart_pkg::*;

module uart_rx_multi #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 50000000 / (115200 * 16)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  uart_rx_multi_if.slave  bus,
  output logic            o_irq,
  input  logic            UART_RX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  logic [1:0]  r_sync;
  logic        r_rx_prev;
  logic [15:0] r_div;
  logic [15:0] r_tcnt;
  logic [5:0]  r_ctrl;
  rx_state_e   r_state;
  logic [PW-1:0] r_ph;
  logic        r_s0;
  logic        r_s1;
  logic [2:0]  r_bit;
  logic [7:0]  r_data;
  logic        r_perr;
  logic        r_ferr;
  logic        r_zero;
  logic        r_stop2;
  logic        r_push;
  rx_entry_t   r_entry;
  logic        r_ovr;
  logic        r_brk;
  logic        r_irq;
  logic        r_busy;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_rx;
  logic        w_tick;
  logic [15:0] w_div_eff;
  logic [15:0] w_wdiv;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_pop;
  logic        w_div_wr;
  logic        w_clr_ovr;
  logic        w_clr_brk;
  logic        w_ovr_set;
  logic        w_brk_set;
  logic        w_vote;
  logic        w_vote_tick;
  logic        w_last_stop;
  logic        w_par_en;
  logic        w_par_exp;
  parity_e     w_par;
  logic        w_empty;
  logic        w_full;
  logic [AW:0] w_count;
  rx_entry_t   w_head;
  logic [31:0] w_status;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_rx     = r_sync[1];
  assign w_tick   = (r_tcnt == '0);
  assign w_div_eff = (r_div == '0) ? 16'd1 : r_div;
  assign w_wdiv   = (bus.i_wdata[15:0] == '0) ? 16'd1
                                             : bus.i_wdata[15:0];
  assign w_unused = ^bus.i_wdata[31:16];

  assign w_acc     = bus.i_request && r_busy && !r_ready;
  assign w_wr      = w_acc && bus.i_rw;
  assign w_rd      = w_acc && !bus.i_rw;
  assign w_pop     = w_rd && bus.i_address == ADDR_DATA && !w_empty;
  assign w_div_wr  = w_wr && bus.i_address == ADDR_DIV;
  assign w_clr_ovr = w_wr && bus.i_address == ADDR_STATUS
                  && bus.i_wdata[ST_OVR];
  assign w_clr_brk = w_wr && bus.i_address == ADDR_STATUS
                  && bus.i_wdata[ST_BRK];

  assign w_par       = parity_e'(r_ctrl[CTL_PAR_LSB +: 2]);
  assign w_par_en    = (w_par == PAR_EVEN) || (w_par == PAR_ODD);
  assign w_par_exp   = (w_par == PAR_ODD) ? ~^r_data : ^r_data;
  assign w_vote      = vote3(r_s0, r_s1, w_rx);
  assign w_vote_tick = w_tick && r_ph == PH_S2 && r_state != S_IDLE;
  assign w_last_stop = !r_ctrl[CTL_STOP2] || r_stop2;
  assign w_brk_set   = w_vote_tick && r_state == S_STOP && w_last_stop
                    && r_zero && !w_vote;
  assign w_ovr_set   = r_push && w_full && !w_pop;

  assign bus.o_ready = r_ready && bus.i_request;
  assign bus.o_rdata = r_rdata;
  assign o_irq       = r_irq;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div  <= DIV_RESET[15:0];
      r_tcnt <= '0;
    end else if (w_div_wr) begin
      r_div  <= bus.i_wdata[15:0];
      r_tcnt <= w_wdiv - 16'd1;
    end else if (w_tick) begin
      r_tcnt <= w_div_eff - 16'd1;
    end else begin
      r_tcnt <= r_tcnt - 16'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
      r_state   <= S_IDLE;
      r_ph      <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_bit     <= '0;
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_zero    <= 1'b0;
      r_stop2   <= 1'b0;
      r_push    <= 1'b0;
      r_entry   <= '0;
    end else begin
      r_sync    <= {r_sync[0], UART_RX};
      r_rx_prev <= w_rx;
      r_push    <= 1'b0;
      if (r_state == S_IDLE) begin
        if (r_rx_prev && !w_rx) begin
          r_state <= S_START;
          r_ph    <= '0;
          r_bit   <= '0;
          r_data  <= '0;
          r_perr  <= 1'b0;
          r_ferr  <= 1'b0;
          r_zero  <= 1'b1;
          r_stop2 <= 1'b0;
        end
      end else if (w_tick) begin
        r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
        if (r_ph == PH_S0) r_s0 <= w_rx;
        if (r_ph == PH_S1) r_s1 <= w_rx;
        if (r_ph == PH_S2) begin
          if (w_vote) r_zero <= 1'b0;
          unique case (r_state)
            S_START:  if (w_vote) r_state <= S_IDLE;
            S_DATA:   r_data[r_bit] <= w_vote;
            S_PARITY: if (w_vote != w_par_exp) r_perr <= 1'b1;
            S_STOP: begin
              if (!w_vote) r_ferr <= 1'b1;
              // leave mid-bit so a back-to-back start edge is caught
              if (w_last_stop) begin
                r_push  <= 1'b1;
                r_entry <= {r_perr, r_ferr | ~w_vote, r_data};
                r_state <= S_IDLE;
              end
            end
            default: ;
          endcase
        end
        if (r_ph == PH_LAST) begin
          unique case (r_state)
            S_START: r_state <= S_DATA;
            S_DATA: begin
              if (r_bit == {1'b1, r_ctrl[1:0]})
                r_state <= w_par_en ? S_PARITY : S_STOP;
              else
                r_bit <= r_bit + 3'd1;
            end
            S_PARITY: r_state <= S_STOP;
            S_STOP:   r_stop2 <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (r_push),
    .i_wdata (r_entry),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVR]   = r_ovr;
    w_status[ST_BRK]   = r_brk;
    w_status[ST_BUSY]  = (r_state != S_IDLE);
    w_status[ST_CNT_LSB +: AW + 1] = w_count;
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (bus.i_address)
      ADDR_DATA:   w_rd_mux = w_empty ? '0 : {22'b0, w_head};
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_CTRL:   w_rd_mux = {26'b0, r_ctrl};
      ADDR_DIV:    w_rd_mux = {16'b0, r_div};
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ctrl  <= CTRL_RESET;
      r_ovr   <= 1'b0;
      r_brk   <= 1'b0;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ovr <= (r_ovr & ~w_clr_ovr) | w_ovr_set;
      r_brk <= (r_brk & ~w_clr_brk) | w_brk_set;
      r_irq <= (!w_empty && r_ctrl[CTL_IRQ_EN]) || r_ovr || r_brk;
      if (!bus.i_request) begin
        r_busy  <= 1'b0;
        r_ready <= 1'b0;
      end else if (!r_busy) begin
        r_busy <= 1'b1;
      end else if (!r_ready) begin
        r_ready <= 1'b1;
        if (!bus.i_rw) r_rdata <= w_rd_mux;
        else if (bus.i_address == ADDR_CTRL)
          r_ctrl <= bus.i_wdata[5:0];
      end
    end
  end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver, next generation of the peripheral-bus serial receivers. Runtime-programmable baud divisor, data width, parity and stop bits; majority-vote oversampling; per-byte error tagging in a deep FIFO; sticky overrun and break detection. It sits on the peripheral bus beside the UART transmitter and is polled or interrupt-driven by the CPU.

## Interface
- OVERSAMPLE, 16: ticks per bit; even, at least 8.
- FIFO_DEPTH, 16: receive FIFO entries; power of two, at least 2.
- DIV_RESET, 50000000/(115200*16): reset value of the divisor register, in clocks per tick.
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  bus request; held until o_ready, then dropped for at least one cycle.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  2  0 data, 1 status, 2 control, 3 divisor.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data; valid while o_ready is high.
- o_ready  out  1  transaction complete.
- o_irq  out  1  high when FIFO not empty and irq_en, or any sticky error.
- UART_RX  in  1  asynchronous serial line; idle high.

## Operation
- Line passes a 2-flop synchroniser (reset value 1). The receiver uses the synchronised value only.
- Tick generator: a counter reloads divisor−1 and emits a one-cycle tick at 0. A divisor write restarts the counter. Divisor 0 is treated as 1.
- Control register: bits[1:0] data_bits−5 (5..8), bits[3:2] parity (0 none, 1 even, 2 odd, 3 none), bit4 two stop bits, bit5 irq_en. Reset value 0x03 (8N1, irq off).
- FSM IDLE → START → DATA → PARITY (skipped when none) → STOP → IDLE.
- IDLE: a falling edge resets the tick phase counter and enters START.
- Each bit is sampled by majority of 3 at ticks OVERSAMPLE/2−1, /2, /2+1.
- START: voted 1 means a glitch; return to IDLE with no push.
- DATA: LSB first; the word is stored right-aligned and zero-extended to 8 bits.
- PARITY: the error bit is set on mismatch.
- STOP: one or two stop bits; any voted 0 sets the framing error.
- Break: data, parity and stop all 0 sets sticky break. The byte is still pushed with its framing error set.
- After the last stop bit, return to IDLE without waiting for the rest of the bit.
- FIFO entry is 10 bits: {parity_err, frame_err, data[7:0]}. On push with FIFO full, drop the entry and set sticky overrun.
- Data read (address 0): o_rdata = {22'b0, parity_err, frame_err, data}, then pop. Read on empty returns 0 with no pop.
- Status read (address 1): bit0 fifo_empty, bit1 fifo_full, bit2 overrun, bit3 break, bit4 busy (FSM not IDLE), bits[15:8] fill count.
- Status write clears overrun and break where i_wdata bits 2 and 3 are 1 (write-1-to-clear). Other writes to status and data are ignored but still acknowledged.
- Reset: FSM IDLE, FIFO empty, stickies 0, divisor DIV_RESET, control 0x03, o_rdata 0, o_ready 0, o_irq 0.

## Timing
- Every access: o_ready rises exactly 2 cycles after i_request rises and stays high until i_request falls. o_ready falls combinationally with i_request.
- Pop and sticky clear take effect once per transaction, in the cycle o_ready first rises.
- FIFO read data is registered. o_rdata is taken from the head entry with no extra wait.
- Push occurs one cycle after the final stop-bit vote.
- Simultaneous push and pop: both occur and the fill count is unchanged. A pop on full frees a slot for a same-cycle push, so no overrun is raised.
- A sticky clear in the same cycle as a new overrun or break event: the set wins.
- Latency from line to FIFO: start edge + (1 + data + parity + stop) bits − OVERSAMPLE/2 ticks + 3 cycles (synchroniser + push).
- Reset mid-frame aborts the frame; the partial byte is discarded.

## Structure
- Package uart_pkg holds:
  - address constants;
  - parity enum;
  - control and status bit positions;
  - FSM state enum;
  - the FIFO entry struct.
- Sub-module uart_rx_fifo: synchronous FIFO, parameters WIDTH and DEPTH. Outputs empty, full, count and registered head data.

## Test plan
- Divisor 4, 8N1, send 0xA5 → data read returns 0x0A5; status then reads bit0 = 1.
- 7E2 (control 0x16), send 0x41 with correct parity → 0x041. Send again with the parity bit flipped → 0x241.
- 8N1, stop bit driven 0 → 0x1xx. An all-zero frame also sets status bit3; write 0x8 to status → bit3 clears.
- Start pulse of 4 ticks (below midpoint) → no push; status bit4 returns to 0.
- Send FIFO_DEPTH+1 bytes with no reads → fill count 16, bit2 = 1. Reads return the first 16 bytes in order; byte 17 is lost.
- Single-tick 0 glitch in the middle of a data bit of 0xFF → majority vote still yields 0x0FF.
